// File: rtl/bcd_pkg.sv
// Shared types and constants for the two-digit BCD counter and its display scanner.
package bcd_pkg;

  typedef logic [3:0] digit_t;

  typedef enum logic {
    ONES = 1'b0,
    TENS = 1'b1
  } scan_state_t;

  localparam digit_t     BCD_MAX  = 4'd9;
  localparam logic [1:0] SEL_ONES = 2'b01;
  localparam logic [1:0] SEL_TENS = 2'b10;

  // Out-of-range codes load as zero so the counter never leaves valid BCD.
  function automatic digit_t bcd_sanitize(input digit_t d);
    return (d > BCD_MAX) ? digit_t'(0) : d;
  endfunction

endpackage

// File: rtl/bcd_digit_cnt.sv
// One BCD decade: loadable up/down counter with a combinational wrap (carry/borrow) output.
module bcd_digit_cnt
  import bcd_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   step,
  input  logic   up,
  input  logic   load,
  input  digit_t load_digit,
  output digit_t digit,
  output logic   wrap
);

  digit_t digit_q;
  digit_t digit_d;

  // wrap is only meaningful while stepping; it feeds the next decade's step.
  always_comb begin
    wrap = 1'b0;
    if (step) begin
      wrap = up ? (digit_q == BCD_MAX) : (digit_q == digit_t'(0));
    end
  end

  always_comb begin
    digit_d = digit_q;
    if (load) begin
      digit_d = bcd_sanitize(load_digit);
    end else if (step) begin
      if (up) begin
        digit_d = wrap ? digit_t'(0) : digit_q + digit_t'(1);
      end else begin
        digit_d = wrap ? BCD_MAX : digit_q - digit_t'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      digit_q <= '0;
    end else begin
      digit_q <= digit_d;
    end
  end

  assign digit = digit_q;

endmodule

// File: rtl/bcd_scan_counter.sv
// Two-digit BCD up/down counter with prescaler, terminal-count pulse and a
// time-multiplexed digit output for a shared seven-segment decoder.
module bcd_scan_counter
  import bcd_pkg::*;
#(
  parameter int PRESCALE = 4,
  parameter int SCAN_DIV = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [7:0] load_val,
  output logic [7:0] count,
  output logic [3:0] digit,
  output logic [1:0] sel,
  output logic       tc
);

  localparam int PS_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam int SD_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);
  localparam logic [SD_W-1:0] SD_LAST = SD_W'(SCAN_DIV - 1);

  logic [PS_W-1:0] presc_q;
  logic [PS_W-1:0] presc_d;
  logic            step;
  logic            cnt_step;

  digit_t ones_digit;
  digit_t tens_digit;
  logic   ones_wrap;
  logic   tens_wrap;

  logic tc_q;
  logic tc_d;

  scan_state_t     state_q;
  scan_state_t     state_d;
  logic [SD_W-1:0] scan_cnt_q;
  logic [SD_W-1:0] scan_cnt_d;

  // A load wins over a coincident step and restarts the prescale interval.
  always_comb begin
    step     = en && (presc_q == PS_LAST);
    cnt_step = step && !load;
    presc_d  = presc_q;
    if (load) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = step ? '0 : presc_q + PS_W'(1);
    end
  end

  bcd_digit_cnt u_ones (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (cnt_step),
    .up         (up),
    .load       (load),
    .load_digit (load_val[3:0]),
    .digit      (ones_digit),
    .wrap       (ones_wrap)
  );

  bcd_digit_cnt u_tens (
    .clk        (clk),
    .rst_n      (rst_n),
    .step       (ones_wrap),
    .up         (up),
    .load       (load),
    .load_digit (load_val[7:4]),
    .digit      (tens_digit),
    .wrap       (tens_wrap)
  );

  // Tens only wraps when the ones wrapped too, i.e. 99->00 or 00->99.
  always_comb begin
    tc_d = tens_wrap;
  end

  always_comb begin
    scan_cnt_d = scan_cnt_q + SD_W'(1);
    state_d    = state_q;
    if (scan_cnt_q == SD_LAST) begin
      scan_cnt_d = '0;
      state_d    = (state_q == ONES) ? TENS : ONES;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q    <= '0;
      tc_q       <= 1'b0;
      state_q    <= ONES;
      scan_cnt_q <= '0;
    end else begin
      presc_q    <= presc_d;
      tc_q       <= tc_d;
      state_q    <= state_d;
      scan_cnt_q <= scan_cnt_d;
    end
  end

  assign count = {tens_digit, ones_digit};
  assign sel   = (state_q == ONES) ? SEL_ONES : SEL_TENS;
  assign digit = (state_q == ONES) ? ones_digit : tens_digit;
  assign tc    = tc_q;

endmodule

// File: tb/tb_bcd_scan_counter.sv
// Bench for bcd_scan_counter: integer-valued reference model checked every cycle,
// plus directed scenarios with hand-computed values.
module tb_bcd_scan_counter;

  localparam int PRESCALE = 4;
  localparam int SCAN_DIV = 2;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       up;
  logic       load;
  logic [7:0] load_val;
  logic [7:0] count;
  logic [3:0] digit;
  logic [1:0] sel;
  logic       tc;

  int check_count = 0;
  int error_count = 0;

  int m_val = 0;
  int m_ps  = 0;
  int m_cyc = 0;
  bit m_tc  = 1'b0;
  bit tc_seen = 1'b0;

  bcd_scan_counter #(
    .PRESCALE (PRESCALE),
    .SCAN_DIV (SCAN_DIV)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .up       (up),
    .load     (load),
    .load_val (load_val),
    .count    (count),
    .digit    (digit),
    .sel      (sel),
    .tc       (tc)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int nib(input logic [3:0] n);
    return (n > 4'd9) ? 0 : int'(n);
  endfunction

  task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
    check_count++;
    if (actual !== expected) begin
      error_count++;
      $display("[TB] FAIL %s actual=%h expected=%h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic e, input logic u, input logic l, input logic [7:0] lv);
    #1;
    en       = e;
    up       = u;
    load     = l;
    load_val = lv;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Reference model: the count is a plain integer 0..99, the scan phase follows
  // from the number of edges since reset.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_val = 0;
      m_ps  = 0;
      m_cyc = 0;
      m_tc  = 1'b0;
    end else begin
      m_cyc++;
      m_tc = 1'b0;
      if (load) begin
        m_val = nib(load_val[7:4]) * 10 + nib(load_val[3:0]);
        m_ps  = 0;
      end else if (en) begin
        if (m_ps == PRESCALE - 1) begin
          m_ps = 0;
          if (up) begin
            m_tc  = (m_val == 99);
            m_val = (m_val + 1) % 100;
          end else begin
            m_tc  = (m_val == 0);
            m_val = (m_val + 99) % 100;
          end
        end else begin
          m_ps++;
        end
      end
    end
  end

  always @(negedge clk) begin
    logic [1:0] exp_sel;
    logic [7:0] exp_count;
    exp_count = {4'(m_val / 10), 4'(m_val % 10)};
    exp_sel   = (((m_cyc / SCAN_DIV) % 2) == 0) ? 2'b01 : 2'b10;
    checkOutput("model_count", count, exp_count);
    checkOutput("model_sel", {6'd0, sel}, {6'd0, exp_sel});
    checkOutput("model_digit", {4'd0, digit},
                {4'd0, (exp_sel == 2'b01) ? exp_count[3:0] : exp_count[7:4]});
    checkOutput("model_tc", {7'd0, tc}, {7'd0, m_tc});
    if (tc === 1'b1) tc_seen = 1'b1;
  end

  initial begin
    logic [1:0] sel_pat [8];
    logic [3:0] dig_pat [8];
    logic [1:0] prev_sel;
    bit found;

    sel_pat = '{2'b01, 2'b01, 2'b10, 2'b10, 2'b01, 2'b01, 2'b10, 2'b10};
    dig_pat = '{4'd7, 4'd7, 4'd4, 4'd4, 4'd7, 4'd7, 4'd4, 4'd4};

    rst_n = 1'b0; en = 1'b0; up = 1'b0; load = 1'b0; load_val = 8'h00;
    $display("[TB] start");

    waitCycles(1);
    checkOutput("reset_count", count, 8'h00);
    checkOutput("reset_sel", {6'd0, sel}, 8'h01);
    checkOutput("reset_digit", {4'd0, digit}, 8'h00);
    checkOutput("reset_tc", {7'd0, tc}, 8'h00);

    // 40 enabled cycles at PRESCALE=4 gives ten steps
    #1 rst_n = 1'b1;
    tc_seen = 1'b0;
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitCycles(40);
    checkOutput("count_after_40", count, 8'h10);
    checkOutput("tc_never_set", {7'd0, tc_seen}, 8'h00);

    applyStimulus(1'b1, 1'b1, 1'b1, 8'h98);
    waitCycles(1);
    checkOutput("load_98", count, 8'h98);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitCycles(4);
    checkOutput("up_99", count, 8'h99);
    checkOutput("up_99_tc", {7'd0, tc}, 8'h00);
    waitCycles(4);
    checkOutput("up_wrap_00", count, 8'h00);
    checkOutput("up_wrap_tc", {7'd0, tc}, 8'h01);
    waitCycles(1);
    checkOutput("up_wrap_tc_drop", {7'd0, tc}, 8'h00);

    applyStimulus(1'b1, 1'b0, 1'b1, 8'h00);
    waitCycles(1);
    checkOutput("load_00", count, 8'h00);
    applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
    waitCycles(4);
    checkOutput("down_wrap_99", count, 8'h99);
    checkOutput("down_wrap_tc", {7'd0, tc}, 8'h01);
    waitCycles(1);
    checkOutput("down_wrap_tc_drop", {7'd0, tc}, 8'h00);
    waitCycles(3);
    checkOutput("down_98", count, 8'h98);

    // load lands on the step cycle and must win
    waitCycles(3);
    applyStimulus(1'b1, 1'b0, 1'b1, 8'h3C);
    waitCycles(1);
    checkOutput("load_3C", count, 8'h30);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitCycles(3);
    checkOutput("restart_hold", count, 8'h30);
    waitCycles(1);
    checkOutput("restart_step", count, 8'h31);

    applyStimulus(1'b0, 1'b1, 1'b1, 8'hA7);
    waitCycles(1);
    checkOutput("load_A7", count, 8'h07);
    applyStimulus(1'b0, 1'b1, 1'b1, 8'h9F);
    waitCycles(1);
    checkOutput("load_9F", count, 8'h90);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    waitCycles(10);
    checkOutput("en_low_hold", count, 8'h90);

    for (int i = 0; i < 24; i++) begin
      applyStimulus(1'b1, (i % 3) != 0, 1'b0, 8'h00);
      waitCycles(1);
    end

    applyStimulus(1'b0, 1'b1, 1'b1, 8'h47);
    waitCycles(1);
    applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
    prev_sel = sel;
    found = 1'b0;
    for (int k = 0; k < 2 * SCAN_DIV + 2; k++) begin
      waitCycles(1);
      if (prev_sel == 2'b10 && sel == 2'b01) begin
        found = 1'b1;
        break;
      end
      prev_sel = sel;
    end
    checkOutput("scan_sync", {7'd0, found}, 8'h01);
    for (int i = 0; i < 8; i++) begin
      if (i > 0) waitCycles(1);
      checkOutput("scan_sel", {6'd0, sel}, {6'd0, sel_pat[i]});
      checkOutput("scan_digit", {4'd0, digit}, {4'd0, dig_pat[i]});
    end

    applyStimulus(1'b1, 1'b1, 1'b1, 8'h55);
    waitCycles(1);
    checkOutput("load_55", count, 8'h55);
    applyStimulus(1'b1, 1'b1, 1'b0, 8'h00);
    waitCycles(2);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_count", count, 8'h00);
    checkOutput("async_sel", {6'd0, sel}, 8'h01);
    checkOutput("async_digit", {4'd0, digit}, 8'h00);
    checkOutput("async_tc", {7'd0, tc}, 8'h00);
    #1 rst_n = 1'b1;
    waitCycles(3);
    checkOutput("resume_hold", count, 8'h00);
    waitCycles(1);
    checkOutput("resume_step", count, 8'h01);

    waitCycles(2);
    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule

// File: doc/bcd_scan_counter.md
BCD_SCAN_COUNTER -- requirements
Module: bcd_scan_counter

Interface
REQ-001 SHALL have parameter PRESCALE, default 4, meaning enabled clock cycles per count step (legal range >=1).
REQ-002 SHALL have parameter SCAN_DIV, default 2, meaning clock cycles each digit stays selected (legal range >=1).
REQ-003 SHALL have port clk  input  1  single system clock; all state on rising edge.
REQ-004 SHALL have port rst_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port en  input  1  count enable; gates prescaler.
REQ-006 SHALL have port up  input  1  direction: 1 increment, 0 decrement.
REQ-007 SHALL have port load  input  1  synchronous load strobe.
REQ-008 SHALL have port load_val  input  8  two BCD digits, [7:4] tens, [3:0] ones.
REQ-009 SHALL have port count  output  8  current BCD value, [7:4] tens, [3:0] ones.
REQ-010 SHALL have port digit  output  4  BCD code of selected digit, bit3..0 = w,x,y,z of the seven-segment decoder inputs.
REQ-011 SHALL have port sel  output  2  one-hot digit select, active-high: 01 ones, 10 tens.
REQ-012 SHALL have port tc  output  1  one-cycle terminal-count pulse on wrap.

Function
REQ-013 Prescaler SHALL count 0..PRESCALE-1 only while en=1, holding its value while en=0; step occurs on cycle where prescaler = PRESCALE-1 and en=1, prescaler then returns to 0.
REQ-014 On a step with up=1, count SHALL increment in BCD: ones 9->0 carries into tens; 99 -> 00.
REQ-015 On a step with up=0, count SHALL decrement in BCD: ones 0->9 borrows from tens; 00 -> 99.
REQ-016 tc SHALL be 1 for exactly the cycle following the edge that wraps 99->00 (up) or 00->99 (down), else 0.
REQ-017 count SHALL update on the clock edge ending the step cycle (one-cycle latency from step condition).
REQ-018 load=1 SHALL take priority over a step in the same cycle: count <= load_val, prescaler <= 0, tc <= 0.
REQ-019 Any load_val nibble >9 SHALL be loaded as 0 for that digit only.
REQ-020 up SHALL be sampled only on the step cycle; changes between steps have no other effect.
REQ-021 Scan FSM SHALL have states ONES and TENS, running every cycle independent of en/load; each state lasts SCAN_DIV cycles then moves to the other.
REQ-022 sel SHALL be 01 in ONES and 10 in TENS; never 00 or 11.
REQ-023 digit SHALL be combinational from registered count and scan state: count[3:0] in ONES, count[7:4] in TENS.
REQ-024 count SHALL always hold valid BCD (each nibble 0..9).

Reset
REQ-025 rst_n=0 SHALL immediately force count=00, prescaler=0, scan state ONES, scan counter=0, sel=01, digit=0, tc=0.
REQ-026 Reset asserted mid-step or mid-scan SHALL discard pending step and resume from REQ-025 values on first edge after release.

Structure
REQ-027 Shared package bcd_pkg SHALL hold digit_t (4-bit), scan_state_t enum {ONES, TENS}, constant BCD_MAX=9.
REQ-028 Single-digit logic SHALL be sub-module bcd_digit_cnt (step, up, load, load digit in; digit, carry/borrow out), instantiated twice, tens stepped by ones carry/borrow.
REQ-029 digit output SHALL connect directly to the existing seven-segment decoder without further logic.

Verification
REQ-030 Reset, en=1, up=1, PRESCALE=4: after 40 enabled cycles -> count=10, tc never set.
REQ-031 load_val=98, up=1, en=1: count 98->99->00 on successive steps -> tc=1 for one cycle after 99->00 edge only.
REQ-032 load_val=00, up=0 -> next step count=99, tc pulse; following step count=98.
REQ-033 load=1 with load_val=8'h3C on a step cycle -> count=30, prescaler restarts, next step 4 cycles later.
REQ-034 count=47, SCAN_DIV=2 -> sel 01,01,10,10 repeating; digit 7,7,4,4.
REQ-035 rst_n pulsed low mid-count at 55 with en=1 -> count=00, sel=01, tc=0 asynchronously; counting resumes from 00.
